// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encodings, receiver
// state enum, baud divisor calculation and the 3-sample majority vote.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Rounded clock cycles per bit.
  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Majority of three line samples.
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i/wr_data_i  push; accepted when not full or when popping the same cycle
//   rd_en_i         pop head; ignored when empty
//   rd_valid_o      FIFO non-empty
//   rd_data_o       head entry (zero when empty)
//   full_o          FIFO holds DEPTH entries
//   count_o         entries held
module sync_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             empty, do_pop, do_push;

  // Extra pointer MSB distinguishes full from empty.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign do_pop     = rd_en_i & ~empty;
  assign do_push    = wr_en_i & (~full_o | do_pop);
  assign rd_valid_o = ~empty;
  assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable data bits, parity and stop bits, feeding a
// FWFT FIFO of {brk, ferr, perr, data} entries.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rxd             asynchronous serial input, idle high
//   rd_en           pop head entry (ignored when rd_valid=0)
//   rd_valid        FIFO non-empty
//   rd_data         head character
//   rd_perr/rd_ferr/rd_brk  head entry parity error / framing error / break
//   fifo_count      entries held
//   overrun         sticky: frame dropped on full FIFO
//   clr_overrun     clears overrun (a coincident set wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic                          rd_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_overrun
);

  localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned BIT_W = 4;
  localparam int unsigned ENT_W = DATA_BITS + 3;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 pbit_q, pbit_d;
  logic                 ferr_q, ferr_d;
  logic                 stop0_low_q, stop0_low_d;
  logic                 wr_en_q, wr_en_d;
  logic [ENT_W-1:0]     wr_data_q, wr_data_d;
  logic                 overrun_q, overrun_d;

  logic rx_meta_q, rxs_q, rxs_d1_q, rxs_d2_q;
  logic fall, maj, sample, brk_c, ferr_c;
  logic fifo_full, fifo_valid;
  logic [ENT_W-1:0] fifo_data;

  // Majority taken over the last three synchronised samples, so the vote is
  // centred one cycle before the decision cycle.
  assign fall   = rxs_d1_q & ~rxs_q;
  assign maj    = maj3({rxs_q, rxs_d1_q, rxs_d2_q});
  assign sample = (cnt_q == CNT_W'(DIV - 1));

  // Receiver next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    data_d      = data_q;
    perr_d      = perr_q;
    pbit_d      = pbit_q;
    ferr_d      = ferr_q;
    stop0_low_d = stop0_low_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    brk_c       = 1'b0;
    ferr_c      = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d     = RX_START;
          bit_d       = '0;
          perr_d      = 1'b0;
          pbit_d      = 1'b0;
          ferr_d      = 1'b0;
          stop0_low_d = 1'b0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF)) begin
          cnt_d   = '0;
          state_d = maj ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (sample) begin
          cnt_d  = '0;
          data_d = {maj, data_q[DATA_BITS-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (sample) begin
          cnt_d   = '0;
          pbit_d  = maj;
          perr_d  = (PARITY == PAR_ODD) ? ~(^data_q ^ maj) : (^data_q ^ maj);
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (sample) begin
          cnt_d = '0;
          if (!maj) ferr_d = 1'b1;
          if (bit_q == '0) stop0_low_d = ~maj;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            // Break: all-zero data, zero parity bit, first stop bit low.
            brk_c     = (data_q == '0) && !pbit_q &&
                        ((bit_q == '0) ? ~maj : stop0_low_q);
            ferr_c    = ferr_q | ~maj | brk_c;
            wr_en_d   = 1'b1;
            wr_data_d = {brk_c, ferr_c, perr_q, data_q};
            bit_d     = '0;
            state_d   = maj ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs_q) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  // Overrun: set on a dropped write, cleared on request; set wins.
  always_comb begin
    overrun_d = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (wr_en_q && fifo_full && !(rd_en && fifo_valid)) overrun_d = 1'b1;
  end

  // Synchroniser, receiver state and write staging.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_d1_q    <= 1'b1;
      rxs_d2_q    <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      pbit_q      <= 1'b0;
      ferr_q      <= 1'b0;
      stop0_low_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rxs_q       <= rx_meta_q;
      rxs_d1_q    <= rxs_q;
      rxs_d2_q    <= rxs_d1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      pbit_q      <= pbit_d;
      ferr_q      <= ferr_d;
      stop0_low_q <= stop0_low_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_q),
    .wr_data_i  (wr_data_q),
    .rd_en_i    (rd_en),
    .rd_valid_o (fifo_valid),
    .rd_data_o  (fifo_data),
    .full_o     (fifo_full),
    .count_o    (fifo_count)
  );

  assign rd_valid = fifo_valid;
  assign rd_data  = fifo_data[DATA_BITS-1:0];
  assign rd_perr  = fifo_data[DATA_BITS];
  assign rd_ferr  = fifo_data[DATA_BITS+1];
  assign rd_brk   = fifo_data[DATA_BITS+2];
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DB     = 8;
  localparam int unsigned PAR    = 2;
  localparam int unsigned SB     = 1;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DIV    = (CLK_HZ + BAUD / 2) / BAUD;

  logic          clk = 1'b0;
  logic          rst, rxd, rd_en, clr_overrun;
  logic          rd_valid, rd_perr, rd_ferr, rd_brk, overrun;
  logic [DB-1:0] rd_data;
  logic [$clog2(DEPTH):0] fifo_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
    logic       brk;
  } ent_t;

  ent_t q[$];
  logic ovr_m;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .PARITY(PAR),
    .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_perr(rd_perr),
    .rd_ferr(rd_ferr), .rd_brk(rd_brk), .fifo_count(fifo_count),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: even parity bit makes the XOR of data and parity zero.
  task automatic model_push(input logic [7:0] d, input logic p, input logic stop_low);
    ent_t e;
    e.d    = d;
    e.perr = p ^ (^d);
    e.brk  = (d == 8'h00) && !p && stop_low;
    e.ferr = stop_low;
    if (q.size() < DEPTH) q.push_back(e);
    else ovr_m = 1'b1;
  endtask

  // Drives one frame; lat = cycles into the stop bit at which rd_valid first seen.
  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic stop_low, output int lat);
    logic p;
    p   = (^d) ^ bad_par;
    lat = -1;
    rxd = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      cyc(DIV);
    end
    rxd = p;
    cyc(DIV);
    rxd = ~stop_low;
    for (int i = 0; i < int'(DIV); i++) begin
      cyc(1);
      if (lat < 0 && rd_valid) lat = i + 1;
    end
    rxd = 1'b1;
    model_push(d, p, stop_low);
    cyc(DIV);
  endtask

  task automatic pop_check(input string tag);
    ent_t e;
    if (q.size() == 0) begin
      chk({tag, "_empty"}, 32'(rd_valid), 32'd0);
      return;
    end
    e = q[0];
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(e.d));
    chk({tag, "_flags"}, 32'({rd_brk, rd_ferr, rd_perr}), 32'({e.brk, e.ferr, e.perr}));
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    void'(q.pop_front());
    chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
  endtask

  initial begin
    int lat;
    int nrd;
    logic [7:0] d;

    rst = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_overrun = 1'b0; ovr_m = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data", 32'({rd_brk, rd_ferr, rd_perr, rd_data}), 32'd0);

    // Basic frame and write latency from stop-bit centre.
    send_frame(8'h55, 1'b0, 1'b0, lat);
    chk("lat_seen", 32'(lat > 0), 32'd1);
    chk("lat_window", 32'((lat - int'(DIV / 2)) >= 1 && (lat - int'(DIV / 2)) <= 6), 32'd1);
    chk("one_entry", 32'(fifo_count), 32'd1);
    pop_check("f55");
    pop_check("f55_after");

    // Short glitch must not produce an entry.
    rxd = 1'b0;
    cyc(4);
    rxd = 1'b1;
    cyc(2 * DIV);
    chk("glitch_count", 32'(fifo_count), 32'd0);
    send_frame(8'hA3, 1'b0, 1'b0, lat);
    pop_check("fA3");

    // Parity error, then correct parity.
    send_frame(8'hA5, 1'b1, 1'b0, lat);
    send_frame(8'hA5, 1'b0, 1'b0, lat);
    pop_check("par_bad");
    pop_check("par_good");

    // Framing error.
    send_frame(8'h3C, 1'b0, 1'b1, lat);
    pop_check("ferr");

    // Break: line low 20 bit times yields exactly one entry.
    rxd = 1'b0;
    cyc(20 * DIV);
    chk("brk_count_low", 32'(fifo_count), 32'd1);
    rxd = 1'b1;
    cyc(2 * DIV);
    chk("brk_count_high", 32'(fifo_count), 32'd1);
    model_push(8'h00, 1'b0, 1'b1);
    pop_check("brk");
    pop_check("brk_after");

    // Overrun with no reads.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, lat);
    chk("ovr_count", 32'(fifo_count), 32'(q.size()));
    chk("ovr_set", 32'(overrun), 32'(ovr_m));
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    ovr_m = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'(ovr_m));
    for (int i = 0; i < 5; i++) pop_check("ovr_pop");

    // Reset in the middle of the data bits discards the partial frame.
    send_frame(8'h11, 1'b0, 1'b0, lat);
    rxd = 1'b0;
    cyc(DIV);
    rxd = 1'b0; cyc(DIV);
    rxd = 1'b1; cyc(DIV);
    rxd = 1'b0; cyc(DIV / 2);
    rst = 1'b1; rxd = 1'b1;
    cyc(2);
    rst = 1'b0;
    q.delete();
    ovr_m = 1'b0;
    cyc(2 * DIV);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_valid", 32'(rd_valid), 32'd0);
    send_frame(8'h7E, 1'b0, 1'b0, lat);
    chk("midrst_one", 32'(fifo_count), 32'd1);
    pop_check("f7E");

    // Random frames with random errors and reads.
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      send_frame(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), lat);
      chk("rnd_count", 32'(fifo_count), 32'(q.size()));
      chk("rnd_ovr", 32'(overrun), 32'(ovr_m));
      if ($urandom_range(0, 3) == 0) begin
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
        ovr_m = 1'b0;
      end
      nrd = $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) pop_check("rnd_pop");
    end
    while (q.size() > 0) pop_check("drain");
    pop_check("drain_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO, replacing the fixed 8N1 receive path in the UART top level. Configurable in baud divisor, data width, parity and stop bits. Recovers frames from the asynchronous `rxd` line, checks parity and framing, detects break, and buffers each character with its error flags in a first-word-fall-through FIFO for the consuming logic.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 115200: line rate; divisor `DIV = (CLK_HZ + BAUD/2) / BAUD` (868 at defaults).
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: power of two, ≥2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rxd` in 1: asynchronous serial input, idle high.
- `rd_en` in 1: pop head entry; ignored when `rd_valid`=0.
- `rd_valid` out 1: FIFO non-empty.
- `rd_data` out DATA_BITS: head character, LSB first on line.
- `rd_perr` out 1: head entry parity error (0 when PARITY=0).
- `rd_ferr` out 1: head entry framing error.
- `rd_brk` out 1: head entry is a break.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: entries held.
- `overrun` out 1: sticky; set when a frame is dropped on full FIFO.
- `clr_overrun` in 1: clears `overrun`; set wins if coincident.

## Operation
- `rxd` through 2-FF synchroniser (`rxs`); all decisions on `rxs`.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: `rxs` falling edge → START, bit counter cleared.
- START: at DIV/2 cycles, majority of `rxs` at DIV/2-1, DIV/2, DIV/2+1; high → IDLE (glitch rejected, nothing written); low → DATA.
- Every bit thereafter sampled DIV cycles after previous sample point, same 3-sample majority.
- DATA: shift LSB first, DATA_BITS samples → PARITY (if PARITY≠0) else STOP.
- PARITY: `perr` = received bit ≠ expected (odd: XOR of data and parity bit must be 1; even: 0).
- STOP: STOP_BITS samples; `ferr` if any sampled low.
- Break: data all zero, parity bit (if any) zero and first stop bit low → `brk`=1, `ferr`=1.
- End of STOP: write {brk, ferr, perr, data} to FIFO; then IDLE, or WAIT_HIGH if last stop bit low. WAIT_HIGH → IDLE only on `rxs` high; no new start while waiting.
- FIFO full at write: entry dropped, `overrun` set, unless `rd_en` same cycle (then pop and push both happen, count unchanged).
- Reset: state IDLE, FIFO empty, `rd_valid`=0, `fifo_count`=0, `overrun`=0, `rd_data`/flags 0; any frame in progress is discarded.

## Timing
- `rxd` to `rxs`: 2 cycles.
- Write occurs the cycle after the final stop-bit sample; `rd_valid` and head data visible the following cycle.
- `rd_en` pop: next head (or `rd_valid`=0) visible next cycle; `fifo_count` updates same edge.
- Pointer wrap at FIFO_DEPTH with extra MSB for full/empty distinction.
- Bit-period counter width $clog2(DIV); reloads at each sample point, no cumulative drift beyond rounding of DIV.

## Structure
- Package `uart_pkg`: parity encoding constants, receiver state enum, `uart_div(clk_hz, baud)` constant function.
- Sub-module `sync_fifo` (WIDTH, DEPTH params, FWFT, count output), width DATA_BITS+3; receiver FSM in the top.

## Test plan
- Defaults, `rxd` sends 0x55 8N1 at 8680 ns/bit → one entry, `rd_data`=0x55, flags 0, `rd_valid` rises within ~4 cycles of stop-bit mid.
- `rxd` low 300 ns then high → no entry, FSM back in IDLE, following valid 0xA3 frame received correctly.
- PARITY=2, send 0xA5 with parity bit 1 (wrong) → `rd_perr`=1, `rd_data`=0xA5; correct parity → `rd_perr`=0.
- Stop bit low on 0x3C, line then high → `rd_ferr`=1, `rd_brk`=0; `rxd` low 20 bit times → single entry 0x00, `rd_brk`=1, no further entries until `rxd` high.
- FIFO_DEPTH=4, five frames 0x01..0x05 with no reads → `fifo_count`=4, `overrun`=1, reads return 0x01..0x04; `clr_overrun` clears it.
- `rst` pulsed mid-DATA, then 0x7E sent → exactly one entry 0x7E, no partial/garbage entry.
